// File: rtl/dpu_mac_pe.sv
// dpu_mac_pe: output-stationary multiply-accumulate PE with a per-column drain chain.
// Build option: define DPU_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module dpu_mac_pe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  k_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  input  logic [DATA_WIDTH-1:0] data_in_b,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  out_valid,
  output logic                  done,
  output logic                  sat_flag,
  input  logic                  drain_load,
  input  logic                  drain_shift,
  input  logic [ACC_WIDTH-1:0]  chain_in,
  output logic [ACC_WIDTH-1:0]  chain_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned MSB = ACC_WIDTH - 1;

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [ACC_WIDTH-1:0] chain;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] k_lat;
  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        b_ext;
  logic [PW-1:0]        prod;
  logic                 prod_sign;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   sum_full;
  logic                 ovf;
  logic                 accept_start;
  logic                 accept_beat;

  // Operands are widened to the full product width first, so the low PW bits
  // of one plain multiply are exact for both signed and unsigned operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{DATA_WIDTH{data_in_a[DATA_WIDTH-1]}}, data_in_a};
      b_ext = {{DATA_WIDTH{data_in_b[DATA_WIDTH-1]}}, data_in_b};
    end else begin
      a_ext = {{DATA_WIDTH{1'b0}}, data_in_a};
      b_ext = {{DATA_WIDTH{1'b0}}, data_in_b};
    end
    prod      = a_ext * b_ext;
    prod_sign = (SIGNED != 0) && prod[PW-1];
    prod_ext  = {ACC_WIDTH{prod_sign}};
    prod_ext[PW-1:0] = prod;
    sum_full  = {1'b0, acc} + {1'b0, prod_ext};
    if (SIGNED != 0)
      ovf = (acc[MSB] == prod_ext[MSB]) && (sum_full[MSB] != acc[MSB]);
    else
      ovf = sum_full[ACC_WIDTH];
  end

`ifdef DPU_SATURATE_EN
  logic [ACC_WIDTH-1:0] sat_val;

  // A signed overflow can only happen when both addends share acc's sign.
  always_comb begin
    if (SIGNED != 0)
      sat_val = acc[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sat_val = '1;
    acc_nxt = ovf ? sat_val : sum_full[ACC_WIDTH-1:0];
  end
`else
  assign acc_nxt = sum_full[ACC_WIDTH-1:0];
`endif

  assign cnt_inc      = cnt + 1'b1;
  assign accept_start = start && (state != S_ACCUM);
  assign accept_beat  = (state == S_ACCUM) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      k_lat    <= '0;
      sat_flag <= 1'b0;
    end else if (accept_start) begin
      acc      <= '0;
      cnt      <= '0;
      k_lat    <= k_len;
      sat_flag <= 1'b0;
      state    <= (k_len == '0) ? S_DONE : S_ACCUM;
    end else if (accept_beat) begin
      acc <= acc_nxt;
      cnt <= cnt_inc;
      if (ovf)
        sat_flag <= 1'b1;
      if (cnt_inc == k_lat)
        state <= S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out_a <= '0;
      data_out_b <= '0;
    end else begin
      out_valid  <= in_valid;
      data_out_a <= in_valid ? data_in_a : '0;
      data_out_b <= in_valid ? data_in_b : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      chain <= '0;
    else if (drain_load)
      chain <= acc;
    else if (drain_shift)
      chain <= chain_in;
  end

  assign done      = (state == S_DONE);
  assign chain_out = chain;

endmodule

// File: tb/tb_dpu_mac_pe.sv
// Bench for dpu_mac_pe: a 3-deep unsigned chain plus signed and 16-bit unsigned PEs,
// checked every cycle against an arithmetic reference model.
module tb_dpu_mac_pe;

  localparam int N = 5;  // 0..2 chain (top..bottom), 3 signed, 4 unsigned 16-bit

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, drain_load, drain_shift;
  logic [7:0] k_len;
  logic [7:0] da [N];
  logic [7:0] db [N];
  logic [7:0] oa [N];
  logic [7:0] ob [N];
  logic       ov [N];
  logic       dn [N];
  logic       sf [N];
  logic [23:0] co [N];

  for (genvar i = 0; i < N; i++) begin : g_pe
    localparam int unsigned WI = (i == 4) ? 16 : 24;
    logic [WI-1:0] cin;
    logic [WI-1:0] cout;
    assign cin   = (i == 1) ? co[0][WI-1:0] : (i == 2) ? co[1][WI-1:0] : '0;
    assign co[i] = 24'(cout);
    dpu_mac_pe #(
      .DATA_WIDTH(8),
      .ACC_WIDTH (WI),
      .CNT_WIDTH (8),
      .SIGNED    ((i == 3) ? 1 : 0)
    ) u_pe (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .k_len      (k_len),
      .in_valid   (in_valid),
      .data_in_a  (da[i]),
      .data_in_b  (db[i]),
      .data_out_a (oa[i]),
      .data_out_b (ob[i]),
      .out_valid  (ov[i]),
      .done       (dn[i]),
      .sat_flag   (sf[i]),
      .drain_load (drain_load),
      .drain_shift(drain_shift),
      .chain_in   (cin),
      .chain_out  (cout)
    );
  end

  // Reference model state
  bit          m_busy [N];
  bit          m_done [N];
  bit          m_sat  [N];
  longint      m_acc  [N];
  int          m_cnt  [N];
  int          m_kl   [N];
  logic [23:0] m_ch   [N];
  logic        m_ov   [N];
  logic [7:0]  m_oa   [N];
  logic [7:0]  m_ob   [N];

  int n_vec = 0;
  int n_err = 0;

  function automatic int width_of(int i);
    return (i == 4) ? 16 : 24;
  endfunction

  function automatic logic [23:0] masked(int i, longint v);
    longint one = 1;
    return 24'(v & ((one << width_of(i)) - 1));
  endfunction

  task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_product(int i);
    longint one = 1;
    longint p, s, mx, mn;
    int     w = width_of(i);
    if (i == 3) begin
      p  = longint'($signed(da[i])) * longint'($signed(db[i]));
      mx = (one << (w - 1)) - 1;
      mn = -(one << (w - 1));
    end else begin
      p  = longint'(da[i]) * longint'(db[i]);
      mx = (one << w) - 1;
      mn = 0;
    end
    s = m_acc[i] + p;
    if (s > mx || s < mn) begin
      m_sat[i] = 1'b1;
`ifdef DPU_SATURATE_EN
      m_acc[i] = (s > mx) ? mx : mn;
`else
      m_acc[i] = (s > mx) ? s - (one << w) : s + (one << w);
`endif
    end else begin
      m_acc[i] = s;
    end
  endtask

  task automatic model_edge();
    longint      acc_pre [N];
    logic [23:0] ch_pre  [N];
    for (int i = 0; i < N; i++) begin
      acc_pre[i] = m_acc[i];
      ch_pre[i]  = m_ch[i];
    end
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_done[i] = 0; m_sat[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
        m_ch[i] = '0; m_ov[i] = 1'b0; m_oa[i] = '0; m_ob[i] = '0;
      end else begin
        m_ov[i] = in_valid;
        m_oa[i] = in_valid ? da[i] : 8'd0;
        m_ob[i] = in_valid ? db[i] : 8'd0;
        if (start && !m_busy[i]) begin
          m_acc[i]  = 0;
          m_cnt[i]  = 0;
          m_sat[i]  = 0;
          m_kl[i]   = int'(k_len);
          m_busy[i] = (k_len != 8'd0);
          m_done[i] = (k_len == 8'd0);
        end else if (m_busy[i] && in_valid) begin
          add_product(i);
          m_cnt[i]++;
          if (m_cnt[i] == m_kl[i]) begin
            m_busy[i] = 0;
            m_done[i] = 1;
          end
        end
        if (drain_load)
          m_ch[i] = masked(i, acc_pre[i]);
        else if (drain_shift)
          m_ch[i] = (i == 1) ? ch_pre[0] : (i == 2) ? ch_pre[1] : 24'd0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("done%0d", i),  24'(dn[i]), 24'(m_done[i]));
      chk($sformatf("sat%0d", i),   24'(sf[i]), 24'(m_sat[i]));
      chk($sformatf("ovld%0d", i),  24'(ov[i]), 24'(m_ov[i]));
      chk($sformatf("outa%0d", i),  24'(oa[i]), 24'(m_oa[i]));
      chk($sformatf("outb%0d", i),  24'(ob[i]), 24'(m_ob[i]));
      chk($sformatf("chain%0d", i), co[i],      m_ch[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      da[i] = 8'($urandom);
      db[i] = 8'($urandom);
    end
  endtask

  task automatic quiet();
    rst = 0; start = 0; in_valid = 0; drain_load = 0; drain_shift = 0;
    k_len = 8'($urandom);
    rand_data();
  endtask

  task automatic go(input logic [7:0] k);
    start = 1; k_len = k;
    tick();
    quiet();
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1;
    for (int i = 0; i < N; i++) begin
      da[i] = a;
      db[i] = b;
    end
    tick();
    quiet();
  endtask

  task automatic load();
    drain_load = 1;
    tick();
    quiet();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_sat[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_kl[i] = 0;
      m_ch[i] = '0; m_ov[i] = 1'b0; m_oa[i] = '0; m_ob[i] = '0;
    end
    quiet();

    // Reset with random activity on the inputs
    for (int c = 0; c < 2; c++) begin
      rst = 1; start = 1'($urandom); in_valid = 1'($urandom);
      drain_load = 1'($urandom); drain_shift = 1'($urandom);
      tick();
      rand_data();
    end
    chk("rst_done", 24'(dn[2]), 24'd0);
    chk("rst_chain", co[2], 24'd0);
    quiet();

    // Unsigned dot product with a gap cycle between beats 1 and 2
    go(8'd3);
    beat(8'd2, 8'd3);
    tick();
    beat(8'd4, 8'd5);
    chk("dot_not_done", 24'(dn[2]), 24'd0);
    beat(8'd255, 8'd255);
    chk("dot_done", 24'(dn[2]), 24'd1);
    load();
    chk("dot_uns", co[2], 24'd65051);

    // Signed dot product
    go(8'd2);
    beat(8'h80, 8'h80);
    beat(8'hFF, 8'd127);
    load();
    chk("sgn_acc", co[3], 24'h003F81);
    chk("sgn_sat", 24'(sf[3]), 24'd0);

    // Overflow on the 16-bit unsigned PE
    go(8'd2);
    beat(8'd255, 8'd255);
    beat(8'd255, 8'd255);
    load();
`ifdef DPU_SATURATE_EN
    chk("ovf_acc", co[4], 24'h00FFFF);
`else
    chk("ovf_acc", co[4], 24'h00FC02);
`endif
    chk("ovf_sat", 24'(sf[4]), 24'd1);

    // k_len = 0, then a back-to-back start in the first done cycle
    go(8'd0);
    chk("k0_done", 24'(dn[2]), 24'd1);
    go(8'd1);
    chk("b2b_restart", 24'(dn[2]), 24'd0);
    beat(8'd3, 8'd3);
    chk("b2b_done", 24'(dn[2]), 24'd1);
    load();
    chk("b2b_acc", co[2], 24'd9);

    // Beat coinciding with start: forwarded, not accumulated
    start = 1; k_len = 8'd1; in_valid = 1;
    for (int i = 0; i < N; i++) begin
      da[i] = 8'd7;
      db[i] = 8'd7;
    end
    tick();
    chk("start_fwd", 24'(oa[2]), 24'd7);
    quiet();
    beat(8'd3, 8'd3);
    load();
    chk("start_beat", co[2], 24'd9);

    // start during ACCUM is ignored
    go(8'd2);
    beat(8'd1, 8'd1);
    go(8'd5);
    beat(8'd2, 8'd2);
    chk("ign_done", 24'(dn[2]), 24'd1);
    load();
    chk("ign_acc", co[2], 24'd5);

    // Reset mid-tile, then a clean tile
    go(8'd3);
    beat(8'd4, 8'd4);
    rst = 1;
    tick();
    chk("abort_done", 24'(dn[2]), 24'd0);
    quiet();
    go(8'd1);
    beat(8'd5, 8'd6);
    chk("clean_done", 24'(dn[2]), 24'd1);
    load();
    chk("clean_acc", co[2], 24'd30);

    // Column drain: 10/20/30 top to bottom
    go(8'd1);
    in_valid = 1;
    da[0] = 8'd10; da[1] = 8'd20; da[2] = 8'd30;
    for (int i = 0; i < N; i++) db[i] = 8'd1;
    tick();
    quiet();
    load();
    chk("drain0", co[2], 24'd30);
    drain_shift = 1;
    tick();
    chk("drain1", co[2], 24'd20);
    tick();
    chk("drain2", co[2], 24'd10);
    drain_load = 1;
    tick();
    chk("load_wins", co[2], 24'd30);
    quiet();

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 7) == 0);
      k_len       = 8'($urandom_range(0, 6));
      in_valid    = 1'($urandom);
      drain_load  = ($urandom_range(0, 5) == 0);
      drain_shift = ($urandom_range(0, 2) == 0);
      rand_data();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dpu_mac_pe.md
# dpu_mac_pe

Parametrised output-stationary multiply-accumulate processing element for the systolic-array datapath. Successor to the 8-bit array cell: it separates operand and accumulator widths, supports signed or unsigned operands, counts a programmed reduction length and raises `done` on the last beat. A per-column shift chain drains finished results out of the array without stopping operand flow. One instance sits at every grid point: A operands flow east, B operands flow south, and results drain south.

## Interface
- `DATA_WIDTH`, 8, operand width for A and B.
- `ACC_WIDTH`, 24, accumulator and result width; must be ≥ 2*`DATA_WIDTH`.
- `CNT_WIDTH`, 8, width of the reduction-length counter.
- `SIGNED`, 1, 1 = two's-complement operands, 0 = unsigned.

- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: one-cycle pulse that begins a new tile.
- `k_len` in `CNT_WIDTH`: number of valid beats to accumulate; sampled when `start` is high.
- `in_valid` in 1: `data_in_a` and `data_in_b` carry a valid beat.
- `data_in_a`, `data_in_b` in `DATA_WIDTH`: operands from the west and north neighbours.
- `data_out_a`, `data_out_b` out `DATA_WIDTH`: registered operands to the east and south neighbours.
- `out_valid` out 1: registered copy of `in_valid`.
- `done` out 1: high while in state DONE.
- `sat_flag` out 1: sticky overflow/saturation indicator; cleared by `start`.
- `drain_load` in 1: copies the accumulator into the chain register.
- `drain_shift` in 1: chain register takes `chain_in`.
- `chain_in` in `ACC_WIDTH`: chain register of the north neighbour (0 at the top row).
- `chain_out` out `ACC_WIDTH`: chain register.

## Operation
- States: IDLE, ACCUM, DONE. Reset state is IDLE.
- `start` in IDLE or DONE:
  - clears acc, cnt and `sat_flag`;
  - latches `k_len`;
  - goes to ACCUM, or to DONE if `k_len`=0.
- `start` in ACCUM is ignored.
- ACCUM with `in_valid`=1:
  - acc ← acc + ext(a*b);
  - cnt ← cnt+1;
  - when cnt+1 == latched k_len, go to DONE.
- A beat arriving in the same cycle as `start` is forwarded but not accumulated.
- `in_valid` in IDLE or DONE is forwarded only; acc is unchanged.
- Product width: full 2*`DATA_WIDTH`, then sign-extended (`SIGNED`=1) or zero-extended to `ACC_WIDTH`. The sum wraps modulo 2^`ACC_WIDTH` unless saturation is compiled in.
- Overflow (signed overflow, or unsigned carry-out) sets `sat_flag` in both builds.
- Operand forwarding is independent of state:
  - `out_valid` ← `in_valid`;
  - `data_out_a`/`data_out_b` ← inputs when `in_valid`=1, else 0.
- Chain:
  - `drain_load`=1 → chain ← acc (acc itself is unchanged);
  - `drain_shift`=1 → chain ← `chain_in`;
  - both asserted → load wins;
  - neither asserted → hold.
  - `drain_load` is legal in any state; the array controller issues it only when `done`=1.

## Timing
- Reset values: `data_out_a`=0, `data_out_b`=0, `out_valid`=0, `done`=0, `sat_flag`=0, `chain_out`=0. Internal acc=0, cnt=0.
- `rst` during ACCUM aborts the tile and returns to IDLE next cycle.
- Forwarding latency is 1 cycle.
- `done` rises in the cycle after the k-th valid beat is sampled. acc is final in that same cycle.
- `done` stays high until the next `start` (falls the cycle after) or `rst`.
- `k_len`=0: `done` rises the cycle after `start`, with acc=0.
- `chain_out` updates 1 cycle after `drain_load`/`drain_shift`. Draining an R-row column takes 1 load + R-1 shifts.
- Back-to-back tiles: `start` may be asserted in the first cycle `done` is high; the new tile begins the next cycle.

## Configuration
- `DPU_SATURATE_EN` defined:
  - on overflow, acc clamps to the maximum or minimum representable value for `SIGNED`;
  - `sat_flag` is set.
- Undefined: acc wraps; `sat_flag` still reports overflow.

## Test plan
- Reset:
  - `rst`=1 for 2 cycles with random inputs → all outputs 0, state IDLE.
  - `rst` mid-ACCUM → `done`=0, and a subsequent tile starts clean.
- Unsigned dot product (`SIGNED`=0):
  - `start` with `k_len`=3;
  - beats (2,3), (4,5), (255,255) with a gap cycle between beats 1 and 2;
  - → `done` 1 cycle after beat 3; load → `chain_out`=65051.
- Signed:
  - `k_len`=2, beats (-128,-128) and (-1,127);
  - → acc=16257 (0x003F81); `sat_flag`=0.
- Overflow with `ACC_WIDTH`=16, `SIGNED`=0:
  - `k_len`=2, beats (255,255)×2;
  - without the macro → acc=0xFC02 and `sat_flag`=1;
  - with `DPU_SATURATE_EN` → acc=0xFFFF and `sat_flag`=1.
- Edge cases:
  - `k_len`=0 → `done` the next cycle, acc=0;
  - `start` with simultaneous `in_valid` → that beat is not accumulated but is forwarded;
  - `start` during ACCUM → ignored.
- Chain of 3 PEs with acc 10/20/30 (top to bottom):
  - load, then 2 shifts;
  - → bottom `chain_out` shows 30, 20, 10 on consecutive cycles;
  - load and shift asserted together → the load value wins.
